stagger_fifo_control: RTL and testbench

//  Load sequencer for the weight/input FIFO bank feeding the systolic array. One start command

---
 rtl/stagger_fifo_control_pkg.sv | 19 +
 rtl/stagger_fifo_control_lane_window_decode.sv | 23 ++
 rtl/stagger_fifo_control.sv | 119 +++++++++++
 tb/tb_stagger_fifo_control.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/stagger_fifo_control_pkg.sv
// Shared types for the array FIFO load sequencer: FSM states, load modes and width helper.
package stagger_fifo_control_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        MODE_PARALLEL = 1'b0,
        MODE_STAGGER  = 1'b1
    } mode_t;

    // Beat counter must reach DEPTH + LANES - 2 in staggered mode, plus headroom for i+len.
    function automatic int cnt_width(input int depth, input int lanes);
        return $clog2(depth + lanes) + 1;
    endfunction

endpackage

// File: rtl/stagger_fifo_control_lane_window_decode.sv
// Per-lane write-enable decode: lane i is open while its beat window covers the current count.
module lane_window_decode
    import stagger_fifo_control_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 6
) (
    input  logic [CNT_W-1:0]      count,
    input  logic [CNT_W-1:0]      len,
    input  logic                  stagger,
    input  logic                  active,
    output logic [FIFO_WIDTH-1:0] enable
);

    for (genvar i = 0; i < FIFO_WIDTH; i++) begin : g_lane
        logic in_window;
        // Staggered lanes are skewed by their index; parallel lanes share lane 0's window.
        assign in_window = stagger ? ((CNT_W'(i) <= count) && (count < (CNT_W'(i) + len)))
                                   : (count < len);
        assign enable[i] = active && in_window;
    end

endmodule

// File: rtl/stagger_fifo_control.sv
// Load sequencer: one start produces per-lane FIFO enables for len beats, parallel or diagonal.
module stagger_fifo_control
    import stagger_fifo_control_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stagger,
    input  logic [$clog2(DEPTH+1)-1:0]   len,
    input  logic                         abort,
    output logic                         ready,
    output logic                         busy,
    output logic [FIFO_WIDTH-1:0]        fifo_en,
    output logic                         weight_write,
    output logic                         done,
    output logic                         aborted
);

    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int CNT_W = cnt_width(DEPTH, FIFO_WIDTH);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic [LEN_W-1:0]  len_c;
    logic [CNT_W-1:0]  total;
    logic              accept;
    logic              last_beat;

    assign len_c     = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
    assign total     = (mode_q == MODE_STAGGER) ? (CNT_W'(len_q) + CNT_W'(FIFO_WIDTH - 1))
                                                : CNT_W'(len_q);
    assign last_beat = (count_q == (total - CNT_W'(1)));
    // An abort in IDLE has no effect of its own but still blocks a same-cycle start.
    assign accept    = start && ready && !abort;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        count_d   = count_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (len_c != '0) begin
                        state_d = ST_RUN;
                        mode_d  = stagger ? MODE_STAGGER : MODE_PARALLEL;
                        len_d   = len_c;
                        count_d = '0;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    count_d   = '0;
                    aborted_d = 1'b1;
                end else if (last_beat) begin
                    state_d   = ST_IDLE;
                    count_d   = '0;
                    done_d    = 1'b1;
                end else begin
                    count_d   = count_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_PARALLEL;
            len_q     <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            count_q   <= count_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign ready        = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_RUN);
    assign weight_write = busy;
    assign done         = done_q;
    assign aborted      = aborted_q;

    // Abort gates the enables in the same cycle it is raised.
    lane_window_decode #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .CNT_W      (CNT_W)
    ) u_decode (
        .count   (count_q),
        .len     (CNT_W'(len_q)),
        .stagger (mode_q == MODE_STAGGER),
        .active  (busy && !abort),
        .enable  (fifo_en)
    );

endmodule

// File: tb/tb_stagger_fifo_control.sv
// Directed table-driven bench for stagger_fifo_control at FIFO_WIDTH=4, DEPTH=4.
module tb_stagger_fifo_control;

    localparam int FW    = 4;
    localparam int DEP   = 4;
    localparam int LEN_W = $clog2(DEP + 1);

    logic             clk = 1'b0;
    logic             reset, start, stagger, abort;
    logic [LEN_W-1:0] len;
    logic             ready, busy, weight_write, done, aborted;
    logic [FW-1:0]    fifo_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            r, s, g;
        bit [2:0]      l;
        bit            a;
        bit            rdy, bsy;
        bit [FW-1:0]   en;
        bit            dn, ab;
    } vec_t;

    vec_t vecs[$];

    stagger_fifo_control #(.FIFO_WIDTH(FW), .DEPTH(DEP)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stagger      (stagger),
        .len          (len),
        .abort        (abort),
        .ready        (ready),
        .busy         (busy),
        .fifo_en      (fifo_en),
        .weight_write (weight_write),
        .done         (done),
        .aborted      (aborted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void add(bit r, bit s, bit g, bit [2:0] l, bit a,
                                bit rdy, bit bsy, bit [FW-1:0] en, bit dn, bit ab);
        vec_t v;
        v.r = r; v.s = s; v.g = g; v.l = l; v.a = a;
        v.rdy = rdy; v.bsy = bsy; v.en = en; v.dn = dn; v.ab = ab;
        vecs.push_back(v);
    endfunction

    function automatic void add_idle(bit r, bit s, bit g, bit [2:0] l, bit a);
        add(r, s, g, l, a, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    endfunction

    initial begin
        // reset held low with start high
        add_idle(0, 1, 0, 4, 0);
        add_idle(0, 1, 0, 4, 0);
        // parallel len=4
        add_idle(1, 1, 0, 4, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 4, 0, 0, 1, 4'hF, 0, 0);
        add(1, 0, 0, 4, 0, 1, 0, 4'h0, 1, 0);
        add_idle(1, 0, 0, 0, 0);
        // stagger len=4
        add_idle(1, 1, 1, 4, 0);
        add(1, 0, 1, 4, 0, 0, 1, 4'h1, 0, 0);
        add(1, 0, 1, 4, 0, 0, 1, 4'h3, 0, 0);
        add(1, 0, 1, 4, 0, 0, 1, 4'h7, 0, 0);
        add(1, 0, 1, 4, 0, 0, 1, 4'hF, 0, 0);
        add(1, 0, 1, 4, 0, 0, 1, 4'hE, 0, 0);
        add(1, 0, 1, 4, 0, 0, 1, 4'hC, 0, 0);
        add(1, 0, 1, 4, 0, 0, 1, 4'h8, 0, 0);
        add(1, 0, 1, 4, 0, 1, 0, 4'h0, 1, 0);
        add_idle(1, 0, 1, 4, 0);
        // stagger len=4, abort in cycle 3
        add_idle(1, 1, 1, 4, 0);
        add(1, 0, 1, 4, 0, 0, 1, 4'h1, 0, 0);
        add(1, 0, 1, 4, 0, 0, 1, 4'h3, 0, 0);
        add(1, 0, 1, 4, 1, 0, 1, 4'h0, 0, 0);
        add(1, 0, 1, 4, 0, 1, 0, 4'h0, 0, 1);
        add_idle(1, 0, 1, 4, 0);
        // start held high, stagger len=2; mode/len wiggled mid-run; back-to-back parallel len=2
        add_idle(1, 1, 1, 2, 0);
        add(1, 1, 0, 2, 0, 0, 1, 4'h1, 0, 0);
        add(1, 1, 0, 4, 0, 0, 1, 4'h3, 0, 0);
        add(1, 1, 0, 4, 0, 0, 1, 4'h6, 0, 0);
        add(1, 1, 0, 2, 0, 0, 1, 4'hC, 0, 0);
        add(1, 1, 0, 2, 0, 0, 1, 4'h8, 0, 0);
        add(1, 1, 0, 2, 0, 1, 0, 4'h0, 1, 0);
        add(1, 0, 0, 2, 0, 0, 1, 4'hF, 0, 0);
        add(1, 0, 0, 2, 0, 0, 1, 4'hF, 0, 0);
        add(1, 0, 0, 2, 0, 1, 0, 4'h0, 1, 0);
        add_idle(1, 0, 0, 2, 0);
        // abort in IDLE blocks a simultaneous start
        add_idle(1, 1, 0, 4, 1);
        add_idle(1, 0, 0, 4, 0);
        // abort on the last RUN cycle wins over done
        add_idle(1, 1, 0, 2, 0);
        add(1, 0, 0, 2, 0, 0, 1, 4'hF, 0, 0);
        add(1, 0, 0, 2, 1, 0, 1, 4'h0, 0, 0);
        add(1, 0, 0, 2, 0, 1, 0, 4'h0, 0, 1);
        add_idle(1, 0, 0, 2, 0);
        // len=0: immediate done, no enables
        add_idle(1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 1, 0, 4'h0, 1, 0);
        add_idle(1, 0, 0, 0, 0);
        // len=7 clamps to DEPTH
        add_idle(1, 1, 0, 7, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 7, 0, 0, 1, 4'hF, 0, 0);
        add(1, 0, 0, 7, 0, 1, 0, 4'h0, 1, 0);
        add_idle(1, 0, 0, 7, 0);
        // reset mid-RUN
        add_idle(1, 1, 0, 4, 0);
        add(1, 0, 0, 4, 0, 0, 1, 4'hF, 0, 0);
        add(0, 0, 0, 4, 0, 0, 1, 4'hF, 0, 0);
        add_idle(1, 0, 0, 4, 0);
        add_idle(1, 0, 0, 4, 0);

        reset = 1'b0; start = 1'b0; stagger = 1'b0; len = '0; abort = 1'b0;
        @(posedge clk);

        foreach (vecs[k]) begin
            @(negedge clk);
            reset   = vecs[k].r;
            start   = vecs[k].s;
            stagger = vecs[k].g;
            len     = LEN_W'(vecs[k].l);
            abort   = vecs[k].a;
            #1;
            check($sformatf("vec%0d {rdy,busy,en,done,abt}", k),
                  int'({ready, busy, fifo_en, done, aborted}),
                  int'({vecs[k].rdy, vecs[k].bsy, vecs[k].en, vecs[k].dn, vecs[k].ab}));
            check($sformatf("vec%0d weight_write", k), int'(weight_write), int'(vecs[k].bsy));
        end

        // stagger len=3: done lands TOTAL+1 = 7 cycles after the start cycle, 12 lane-beats total
        begin
            int cyc   = 0;
            int beats = 0;
            bit found = 1'b0;
            @(negedge clk);
            reset = 1'b1; start = 1'b1; stagger = 1'b1; len = 3; abort = 1'b0;
            while (cyc < 30 && !found) begin
                @(negedge clk);
                start = 1'b0;
                #1;
                cyc++;
                beats += $countones(fifo_en);
                if (done) found = 1'b1;
            end
            check("seq_done_seen", int'(found), 1);
            check("seq_done_latency", cyc, 7);
            check("seq_lane_beats", beats, 12);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
